// File: rtl/regfile_issue_arbiter.sv
// Round-robin arbiter with starvation override for the regfile scoreboard issue port.
// Issue fields go to the scoreboard combinationally; operand responses come back on a shared bus.
module regfile_issue_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ROB_DEPTH  = 4,
  parameter int MAX_WAIT   = 7,
  parameter int FLUSH_HOLD = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           move_flush,
  input  logic                           rob_stall,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*7-1:0]           req_opcode,
  input  logic [NUM_REQ*5-1:0]           req_rd_s,
  input  logic [NUM_REQ*5-1:0]           req_rs1_s,
  input  logic [NUM_REQ*5-1:0]           req_rs2_s,
  input  logic [NUM_REQ*ROB_DEPTH-1:0]   req_rob,
  output logic                           issue_valid,
  output logic [6:0]                     issue_opcode,
  output logic [4:0]                     issue_rd_s,
  output logic [ROB_DEPTH-1:0]           issue_rob,
  output logic [4:0]                     issue_rs1_s,
  output logic [4:0]                     issue_rs2_s,
  input  logic [31:0]                    rf_rs1_v,
  input  logic [31:0]                    rf_rs2_v,
  input  logic                           rf_rs1_ready,
  input  logic                           rf_rs2_ready,
  input  logic [ROB_DEPTH-1:0]           rf_rs1_rob,
  input  logic [ROB_DEPTH-1:0]           rf_rs2_rob,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [31:0]                    resp_rs1_v,
  output logic [31:0]                    resp_rs2_v,
  output logic                           resp_rs1_ready,
  output logic                           resp_rs2_ready,
  output logic [ROB_DEPTH-1:0]           resp_rs1_rob,
  output logic [ROB_DEPTH-1:0]           resp_rs2_rob
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int HOLD_W = (FLUSH_HOLD > 0) ? $clog2(FLUSH_HOLD + 1) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [WAIT_W-1:0] wait_cnt [NUM_REQ];
  logic [HOLD_W-1:0] hold_cnt;

  logic               en;
  logic               found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic [NUM_REQ-1:0] grant;

  // Flush cycle itself is blanked so a scoreboard write never races its clear.
  assign en = !rst && !move_flush && !rob_stall && (hold_cnt == '0);

  // NOTE: every variable gets a default before any conditional assignment,
  // otherwise the unassigned paths would infer latches.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    grant     = '0;
    if (en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (wait_cnt[i] == WAIT_W'(MAX_WAIT))) begin
          found     = 1'b1;
          grant_idx = PTR_W'(i);
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (!found && req_valid[scan_idx]) begin
          found     = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = found && (grant_idx == PTR_W'(i));
    end
  end

  // Scoreboard issue port: fields of the granted slice, all zero when idle.
  always_comb begin
    issue_opcode = '0;
    issue_rd_s   = '0;
    issue_rs1_s  = '0;
    issue_rs2_s  = '0;
    issue_rob    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        issue_opcode = req_opcode[7*i +: 7];
        issue_rd_s   = req_rd_s[5*i +: 5];
        issue_rs1_s  = req_rs1_s[5*i +: 5];
        issue_rs2_s  = req_rs2_s[5*i +: 5];
        issue_rob    = req_rob[ROB_DEPTH*i +: ROB_DEPTH];
      end
    end
  end

  assign issue_valid = |grant;
  assign req_ready   = grant;
  assign resp_valid  = grant;

  // Operand bus is shared; only the one-hot resp_valid tells a requester it is theirs.
  assign resp_rs1_v     = rst ? '0   : rf_rs1_v;
  assign resp_rs2_v     = rst ? '0   : rf_rs2_v;
  assign resp_rs1_ready = rst ? 1'b0 : rf_rs1_ready;
  assign resp_rs2_ready = rst ? 1'b0 : rf_rs2_ready;
  assign resp_rs1_rob   = rst ? '0   : rf_rs1_rob;
  assign resp_rs2_rob   = rst ? '0   : rf_rs2_rob;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      hold_cnt <= '0;
      // NOTE: wait_cnt is a tiny architecturally visible counter array, so it
      // is reset explicitly, unlike a data memory that would be left unreset.
      for (int j = 0; j < NUM_REQ; j++) wait_cnt[j] <= '0;
    end else if (move_flush) begin
      rr_ptr   <= '0;
      hold_cnt <= HOLD_W'(FLUSH_HOLD);
      for (int j = 0; j < NUM_REQ; j++) wait_cnt[j] <= '0;
    end else begin
      if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
      if (found) begin
        rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!req_valid[j] || grant[j]) begin
          wait_cnt[j] <= '0;
        end else if (en && (wait_cnt[j] != WAIT_W'(MAX_WAIT))) begin
          wait_cnt[j] <= wait_cnt[j] + WAIT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_issue_arbiter.sv
// Directed bench: expectations queued when a step is driven, popped and compared mid-cycle.
// A second instance with MAX_WAIT=1 lets the starvation override pre-empt round-robin with three requesters.
module tb_regfile_issue_arbiter;

  localparam int NR = 3;
  localparam int RD = 4;

  localparam logic [6:0] OP_TAB  [NR] = '{7'h13, 7'h33, 7'h63};
  localparam logic [4:0] RDS_TAB [NR] = '{5'd1, 5'd2, 5'd3};
  localparam logic [4:0] RS1_TAB [NR] = '{5'd1, 5'd2, 5'd5};
  localparam logic [4:0] RS2_TAB [NR] = '{5'd7, 5'd8, 5'd9};
  localparam logic [3:0] ROB_TAB [NR] = '{4'h1, 4'h6, 4'hA};

  localparam logic [31:0] RF1_V   = 32'hDEADBEEF;
  localparam logic [31:0] RF2_V   = 32'h0BADF00D;
  localparam logic        RF1_RDY = 1'b0;
  localparam logic        RF2_RDY = 1'b1;
  localparam logic [3:0]  RF1_ROB = 4'd3;
  localparam logic [3:0]  RF2_ROB = 4'hC;

  typedef struct {
    int         idx;
    logic [2:0] grant;
    logic [2:0] grant_b;
    logic       check_b;
    logic       in_rst;
  } exp_t;

  exp_t  sb [$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    step_no     = 0;
  string cur_name    = "";

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, move_flush, rob_stall;
  logic [NR-1:0]   req_valid;
  logic [NR*7-1:0] req_opcode;
  logic [NR*5-1:0] req_rd_s, req_rs1_s, req_rs2_s;
  logic [NR*RD-1:0] req_rob;
  logic [31:0]     rf_rs1_v, rf_rs2_v;
  logic            rf_rs1_ready, rf_rs2_ready;
  logic [RD-1:0]   rf_rs1_rob, rf_rs2_rob;

  logic [NR-1:0] req_ready, resp_valid;
  logic          issue_valid;
  logic [6:0]    issue_opcode;
  logic [4:0]    issue_rd_s, issue_rs1_s, issue_rs2_s;
  logic [RD-1:0] issue_rob;
  logic [31:0]   resp_rs1_v, resp_rs2_v;
  logic          resp_rs1_ready, resp_rs2_ready;
  logic [RD-1:0] resp_rs1_rob, resp_rs2_rob;

  logic [NR-1:0] b_req_ready, b_resp_valid;
  logic          b_issue_valid;
  logic [6:0]    b_issue_opcode;
  logic [4:0]    b_issue_rd_s, b_issue_rs1_s, b_issue_rs2_s;
  logic [RD-1:0] b_issue_rob;
  logic [31:0]   b_resp_rs1_v, b_resp_rs2_v;
  logic          b_resp_rs1_ready, b_resp_rs2_ready;
  logic [RD-1:0] b_resp_rs1_rob, b_resp_rs2_rob;

  regfile_issue_arbiter #(.NUM_REQ(NR), .ROB_DEPTH(RD), .MAX_WAIT(2), .FLUSH_HOLD(2)) dut (
    .clk(clk), .rst(rst), .move_flush(move_flush), .rob_stall(rob_stall),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_rd_s(req_rd_s), .req_rs1_s(req_rs1_s),
    .req_rs2_s(req_rs2_s), .req_rob(req_rob),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_rd_s(issue_rd_s),
    .issue_rob(issue_rob), .issue_rs1_s(issue_rs1_s), .issue_rs2_s(issue_rs2_s),
    .rf_rs1_v(rf_rs1_v), .rf_rs2_v(rf_rs2_v), .rf_rs1_ready(rf_rs1_ready),
    .rf_rs2_ready(rf_rs2_ready), .rf_rs1_rob(rf_rs1_rob), .rf_rs2_rob(rf_rs2_rob),
    .resp_valid(resp_valid), .resp_rs1_v(resp_rs1_v), .resp_rs2_v(resp_rs2_v),
    .resp_rs1_ready(resp_rs1_ready), .resp_rs2_ready(resp_rs2_ready),
    .resp_rs1_rob(resp_rs1_rob), .resp_rs2_rob(resp_rs2_rob)
  );

  regfile_issue_arbiter #(.NUM_REQ(NR), .ROB_DEPTH(RD), .MAX_WAIT(1), .FLUSH_HOLD(2)) dut_mw1 (
    .clk(clk), .rst(rst), .move_flush(move_flush), .rob_stall(rob_stall),
    .req_valid(req_valid), .req_ready(b_req_ready),
    .req_opcode(req_opcode), .req_rd_s(req_rd_s), .req_rs1_s(req_rs1_s),
    .req_rs2_s(req_rs2_s), .req_rob(req_rob),
    .issue_valid(b_issue_valid), .issue_opcode(b_issue_opcode), .issue_rd_s(b_issue_rd_s),
    .issue_rob(b_issue_rob), .issue_rs1_s(b_issue_rs1_s), .issue_rs2_s(b_issue_rs2_s),
    .rf_rs1_v(rf_rs1_v), .rf_rs2_v(rf_rs2_v), .rf_rs1_ready(rf_rs1_ready),
    .rf_rs2_ready(rf_rs2_ready), .rf_rs1_rob(rf_rs1_rob), .rf_rs2_rob(rf_rs2_rob),
    .resp_valid(b_resp_valid), .resp_rs1_v(b_resp_rs1_v), .resp_rs2_v(b_resp_rs2_v),
    .resp_rs1_ready(b_resp_rs1_ready), .resp_rs2_ready(b_resp_rs2_ready),
    .resp_rs1_rob(b_resp_rs1_rob), .resp_rs2_rob(b_resp_rs2_rob)
  );

  function automatic logic [26:0] issue_model(input logic [2:0] g);
    issue_model = '0;
    for (int i = 0; i < NR; i++) begin
      if (g[i]) issue_model = {1'b1, OP_TAB[i], RDS_TAB[i], ROB_TAB[i], RS1_TAB[i], RS2_TAB[i]};
    end
  endfunction

  // Requester contract on the main instance: a pending request may only drop
  // once granted, except around reset or flush, which cancel in-flight requests.
  logic [NR-1:0] prev_valid = '0;
  logic [NR-1:0] prev_ready = '0;
  logic          mon_skip   = 1'b1;
  always @(posedge clk) begin
    if (!mon_skip && !rst && !move_flush) begin
      for (int i = 0; i < NR; i++) begin
        if (prev_valid[i] && !prev_ready[i]) begin
          assert (req_valid[i] === 1'b1) else begin
            miscompares++;
            $error("FAIL contract req%0d: valid dropped to %b before grant, required 1", i, req_valid[i]);
          end
        end
      end
    end
    prev_valid <= req_valid;
    prev_ready <= req_ready;
    mon_skip   <= rst || move_flush;
  end

  task automatic step(input string name, input logic [2:0] valid, input logic flush,
                      input logic stall, input logic reset, input logic [2:0] exp_a,
                      input logic chk_b, input logic [2:0] exp_b);
    exp_t        e;
    logic [26:0] exp_issue, got_issue;
    logic [76:0] exp_resp, got_resp;
    @(negedge clk);
    rst        = reset;
    move_flush = flush;
    rob_stall  = stall;
    req_valid  = valid;
    step_no++;
    cur_name = name;
    e.idx = step_no; e.grant = exp_a; e.grant_b = exp_b; e.check_b = chk_b; e.in_rst = reset;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    exp_issue = issue_model(e.grant);
    got_issue = {issue_valid, issue_opcode, issue_rd_s, issue_rob, issue_rs1_s, issue_rs2_s};
    exp_resp  = e.in_rst ? '0 : {e.grant, RF1_V, RF2_V, RF1_RDY, RF2_RDY, RF1_ROB, RF2_ROB};
    got_resp  = {resp_valid, resp_rs1_v, resp_rs2_v, resp_rs1_ready, resp_rs2_ready,
                 resp_rs1_rob, resp_rs2_rob};
    vectors++;
    assert (req_ready === e.grant) else begin
      miscompares++;
      $error("FAIL %s#%0d grant: got %b want %b", cur_name, e.idx, req_ready, e.grant);
    end
    vectors++;
    assert (got_issue === exp_issue) else begin
      miscompares++;
      $error("FAIL %s#%0d issue: got %h want %h", cur_name, e.idx, got_issue, exp_issue);
    end
    vectors++;
    assert (got_resp === exp_resp) else begin
      miscompares++;
      $error("FAIL %s#%0d resp: got %h want %h", cur_name, e.idx, got_resp, exp_resp);
    end
    if (e.check_b) begin
      vectors++;
      assert (b_req_ready === e.grant_b) else begin
        miscompares++;
        $error("FAIL %s#%0d grant_mw1: got %b want %b", cur_name, e.idx, b_req_ready, e.grant_b);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at step %0d", step_no);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; move_flush = 1'b0; rob_stall = 1'b0; req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      req_opcode[7*i +: 7]   = OP_TAB[i];
      req_rd_s[5*i +: 5]     = RDS_TAB[i];
      req_rs1_s[5*i +: 5]    = RS1_TAB[i];
      req_rs2_s[5*i +: 5]    = RS2_TAB[i];
      req_rob[RD*i +: RD]    = ROB_TAB[i];
    end
    rf_rs1_v = RF1_V; rf_rs2_v = RF2_V;
    rf_rs1_ready = RF1_RDY; rf_rs2_ready = RF2_RDY;
    rf_rs1_rob = RF1_ROB; rf_rs2_rob = RF2_ROB;

    //    name        valid  fl    st    rst   exp_a  chkb  exp_b
    step("reset",    3'b111, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000);
    step("rr",       3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000);
    step("rr",       3'b111, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 3'b000);
    step("rr",       3'b111, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 3'b000);
    step("rr",       3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000);
    step("rr",       3'b111, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 3'b000);
    step("rr",       3'b111, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 3'b000);
    step("rr",       3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000);
    step("flush",    3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    step("hold",     3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    step("hold",     3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    step("post_fl",  3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000);
    step("flush2",   3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    step("hold2",    3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    step("reflush",  3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    step("hold3",    3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    step("hold3",    3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    step("post_fl2", 3'b111, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000);
    step("fl_stall", 3'b001, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    step("hold4",    3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    step("hold4",    3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    step("stall",    3'b001, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    step("stall",    3'b001, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    step("stall",    3'b001, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000);
    step("release",  3'b001, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 3'b001);
    step("starve",   3'b011, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 3'b010);
    step("starve",   3'b101, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 3'b001);
    step("starve",   3'b101, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 3'b100);
    step("steer",    3'b100, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 3'b000);
    step("pre_rst",  3'b011, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000);
    step("mid_rst",  3'b010, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 3'b000);
    step("post_rst", 3'b011, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000);
    step("post_rst", 3'b010, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 3'b000);
    step("idle",     3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
